// File: rtl/dungeon_pkg.sv
// Shared types and width helpers for the dungeon grid game controller.
// Imported by the position tracker and the top-level FSM.
package dungeon_pkg;

    typedef enum logic [2:0] {
        EXPLORE = 3'd0,
        COMBAT  = 3'd1,
        VICTORY = 3'd2,
        DEPART  = 3'd3,
        DEAD    = 3'd4
    } game_state_e;

    typedef enum logic [2:0] {
        DIR_NONE = 3'd0,
        DIR_N    = 3'd1,
        DIR_S    = 3'd2,
        DIR_E    = 3'd3,
        DIR_W    = 3'd4
    } dir_e;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int moves_width(input int max_moves);
        return clog2_min1(max_moves + 1);
    endfunction

    // Anything other than exactly one button is treated as no request.
    function automatic dir_e decode_dir(
        input logic n,
        input logic s,
        input logic e,
        input logic w
    );
        case ({n, s, e, w})
            4'b1000: return DIR_N;
            4'b0100: return DIR_S;
            4'b0010: return DIR_E;
            4'b0001: return DIR_W;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dungeon_pos_tracker.sv
// Player position register with grid-edge blocking and one-hot room decode.
// The owning FSM decides when a move is taken or the start room is reloaded.
module dungeon_pos_tracker
    import dungeon_pkg::*;
#(
    parameter int COLS      = 3,
    parameter int ROWS      = 3,
    parameter int START_IDX = 0,
    parameter int XW        = clog2_min1(COLS),
    parameter int YW        = clog2_min1(ROWS),
    parameter int IW        = clog2_min1(ROWS * COLS)
) (
    input  logic                   clk,
    input  logic                   load_start,
    input  logic                   enable,
    input  dir_e                   dir,
    output logic [XW-1:0]          pos_x,
    output logic [YW-1:0]          pos_y,
    output logic                   blocked,
    output logic [IW-1:0]          next_idx,
    output logic [ROWS*COLS-1:0]   room_onehot
);

    localparam logic [XW-1:0] START_X = XW'(START_IDX % COLS);
    localparam logic [YW-1:0] START_Y = YW'(START_IDX / COLS);
    localparam logic [XW-1:0] X_MAX   = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(ROWS - 1);

    logic [XW-1:0] x_q, x_d, nx;
    logic [YW-1:0] y_q, y_d, ny;
    logic [IW-1:0] cur_idx;

    always_comb begin
        nx      = x_q;
        ny      = y_q;
        blocked = 1'b0;
        case (dir)
            DIR_N: if (y_q == '0) blocked = 1'b1;
                   else ny = y_q - YW'(1);
            DIR_S: if (y_q == Y_MAX) blocked = 1'b1;
                   else ny = y_q + YW'(1);
            DIR_E: if (x_q == X_MAX) blocked = 1'b1;
                   else nx = x_q + XW'(1);
            DIR_W: if (x_q == '0) blocked = 1'b1;
                   else nx = x_q - XW'(1);
            default: ;
        endcase
        next_idx = IW'(int'(ny) * COLS + int'(nx));
        cur_idx  = IW'(int'(y_q) * COLS + int'(x_q));
        x_d = x_q;
        y_d = y_q;
        if (load_start) begin
            x_d = START_X;
            y_d = START_Y;
        end else if (enable) begin
            x_d = nx;
            y_d = ny;
        end
    end

    always_comb begin
        room_onehot = '0;
        for (int i = 0; i < ROWS * COLS; i++) begin
            room_onehot[i] = (cur_idx == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        x_q <= x_d;
        y_q <= y_d;
    end

    assign pos_x = x_q;
    assign pos_y = y_q;

endmodule

// File: rtl/dungeon_grid_fsm.sv
// Adventure-game controller: room grid walk, sticky items, move limit
// and a single-cycle dragon combat resolution.
module dungeon_grid_fsm
    import dungeon_pkg::*;
#(
    parameter int COLS       = 3,
    parameter int ROWS       = 3,
    parameter int START_IDX  = 0,
    parameter int SWORD_IDX  = 6,
    parameter int WIZARD_IDX = 2,
    parameter int DRAGON_IDX = 8,
    parameter int MAX_MOVES  = 20
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               n,
    input  logic                               s,
    input  logic                               e,
    input  logic                               w,
    output logic [ROWS*COLS-1:0]               room_onehot,
    output logic [clog2_min1(COLS)-1:0]        pos_x,
    output logic [clog2_min1(ROWS)-1:0]        pos_y,
    output logic [moves_width(MAX_MOVES)-1:0]  moves,
    output logic [2:0]                         game_state,
    output logic                               sw,
    output logic                               wz,
    output logic                               win,
    output logic                               dead,
    output logic                               bump
);

    localparam int NR = ROWS * COLS;
    localparam int IW = clog2_min1(NR);
    localparam int MW = moves_width(MAX_MOVES);
    localparam logic [MW-1:0] MOVE_LIMIT = MW'(MAX_MOVES);

    if (START_IDX >= NR || SWORD_IDX >= NR ||
        WIZARD_IDX >= NR || DRAGON_IDX >= NR ||
        START_IDX == SWORD_IDX || START_IDX == WIZARD_IDX ||
        START_IDX == DRAGON_IDX || SWORD_IDX == WIZARD_IDX ||
        SWORD_IDX == DRAGON_IDX || WIZARD_IDX == DRAGON_IDX ||
        COLS < 2 || ROWS < 2 || MAX_MOVES < 1) begin : g_bad_cfg
        $fatal(1, "dungeon_grid_fsm: bad room/grid parameters");
    end

    game_state_e   state_q, state_d;
    logic [MW-1:0] moves_q, moves_d;
    logic          sw_q, sw_d;
    logic          wz_q, wz_d;
    logic          bump_q, bump_d;
    logic          restart;
    logic          move_en;
    logic          blocked;
    logic [IW-1:0] next_idx;
    dir_e          dir;

    assign dir = decode_dir(n, s, e, w);

    dungeon_pos_tracker #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .START_IDX (START_IDX)
    ) u_pos (
        .clk         (clk),
        .load_start  (reset | restart),
        .enable      (move_en),
        .dir         (dir),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .blocked     (blocked),
        .next_idx    (next_idx),
        .room_onehot (room_onehot)
    );

    always_comb begin
        state_d = state_q;
        moves_d = moves_q;
        sw_d    = sw_q;
        wz_d    = wz_q;
        bump_d  = 1'b0;
        restart = 1'b0;
        move_en = 1'b0;
        if (start) begin
            state_d = EXPLORE;
            moves_d = '0;
            sw_d    = 1'b0;
            wz_d    = 1'b0;
            restart = 1'b1;
        end else begin
            case (state_q)
                EXPLORE: begin
                    if (dir != DIR_NONE && blocked) begin
                        bump_d = 1'b1;
                    end else if (dir != DIR_NONE) begin
                        move_en = 1'b1;
                        if (moves_q != MOVE_LIMIT) moves_d = moves_q + MW'(1);
                        sw_d = sw_q | (next_idx == IW'(SWORD_IDX));
                        wz_d = wz_q | (next_idx == IW'(WIZARD_IDX));
                        // Reaching the dragon wins over running out of moves.
                        if (next_idx == IW'(DRAGON_IDX)) state_d = COMBAT;
                        else if (moves_d == MOVE_LIMIT) state_d = DEAD;
                    end
                end
                COMBAT: begin
                    if (wz_q)      state_d = DEPART;
                    else if (sw_q) state_d = VICTORY;
                    else           state_d = DEAD;
                end
                VICTORY, DEPART, DEAD: ;
                default: begin
                    state_d = EXPLORE;
                    moves_d = '0;
                    sw_d    = 1'b0;
                    wz_d    = 1'b0;
                    restart = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EXPLORE;
            moves_q <= '0;
            sw_q    <= 1'b0;
            wz_q    <= 1'b0;
            bump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            moves_q <= moves_d;
            sw_q    <= sw_d;
            wz_q    <= wz_d;
            bump_q  <= bump_d;
        end
    end

    assign moves      = moves_q;
    assign game_state = state_q;
    assign sw         = sw_q;
    assign wz         = wz_q;
    assign bump       = bump_q;
    assign win        = (state_q == VICTORY) || (state_q == DEPART);
    assign dead       = (state_q == DEAD);

endmodule

// File: tb/tb_dungeon_grid_fsm.sv
// Directed bench for dungeon_grid_fsm at default parameters.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_dungeon_grid_fsm;

    logic       clk = 1'b0;
    logic       reset, start, n, s, e, w;
    logic [8:0] room_onehot;
    logic [1:0] pos_x, pos_y;
    logic [4:0] moves;
    logic [2:0] game_state;
    logic       sw, wz, win, dead, bump;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] DN   = 4'b1000;
    localparam logic [3:0] DS   = 4'b0100;
    localparam logic [3:0] DE   = 4'b0010;
    localparam logic [3:0] DW   = 4'b0001;

    dungeon_grid_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .n           (n),
        .s           (s),
        .e           (e),
        .w           (w),
        .room_onehot (room_onehot),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .moves       (moves),
        .game_state  (game_state),
        .sw          (sw),
        .wz          (wz),
        .win         (win),
        .dead        (dead),
        .bump        (bump)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] nsew);
        {n, s, e, w} = nsew;
        @(posedge clk);
        #1;
        {n, s, e, w} = NONE;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(NONE);
        start = 1'b0;
    endtask

    task automatic chk_home(input string tag);
        chk({tag, "_room"}, 32'(room_onehot), 32'h001);
        chk({tag, "_pos"}, {28'd0, pos_y, pos_x}, 32'h0);
        chk({tag, "_moves"}, 32'(moves), 32'd0);
        chk({tag, "_state"}, 32'(game_state), 32'd0);
        chk({tag, "_flags"}, {27'd0, sw, wz, win, dead, bump}, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        {n, s, e, w} = NONE;
        cyc(NONE);
        cyc(NONE);
        reset = 1'b0;
        chk_home("reset");

        cyc(DN);
        chk("bump_n", 32'(bump), 32'd1);
        chk("bump_pos", 32'(room_onehot), 32'h001);
        chk("bump_moves", 32'(moves), 32'd0);
        cyc(NONE);
        chk("bump_clear", 32'(bump), 32'd0);

        cyc(DN | DE);
        chk("multi_room", 32'(room_onehot), 32'h001);
        chk("multi_bump", 32'(bump), 32'd0);
        chk("multi_moves", 32'(moves), 32'd0);

        // slay path: s,s picks up sword at room 6, e,e reaches dragon
        cyc(DS);
        chk("slay_s1", 32'(room_onehot), 32'h008);
        chk("slay_m1", 32'(moves), 32'd1);
        cyc(DS);
        chk("slay_sword_room", 32'(room_onehot), 32'h040);
        chk("slay_sw", 32'(sw), 32'd1);
        chk("slay_wz", 32'(wz), 32'd0);
        cyc(DE);
        chk("slay_e1", 32'(room_onehot), 32'h080);
        chk("slay_st_e1", 32'(game_state), 32'd0);
        cyc(DE);
        chk("slay_combat", 32'(game_state), 32'd1);
        chk("slay_dragon", 32'(room_onehot), 32'h100);
        chk("slay_win0", 32'(win), 32'd0);
        cyc(DW);
        chk("slay_victory", 32'(game_state), 32'd2);
        chk("slay_win", 32'(win), 32'd1);
        chk("slay_dead", 32'(dead), 32'd0);
        chk("slay_moves", 32'(moves), 32'd4);
        chk("slay_pos_hold", {28'd0, pos_y, pos_x}, 32'hA);
        cyc(DN);
        chk("slay_term_hold", 32'(room_onehot), 32'h100);
        chk("slay_term_bump", 32'(bump), 32'd0);
        pulse_start();
        chk_home("start1");

        // no items: e,s,e,s
        cyc(DE);
        cyc(DS);
        cyc(DE);
        chk("noitem_r5", 32'(room_onehot), 32'h020);
        cyc(DS);
        chk("noitem_combat", 32'(game_state), 32'd1);
        cyc(NONE);
        chk("noitem_dead_st", 32'(game_state), 32'd4);
        chk("noitem_dead", 32'(dead), 32'd1);
        chk("noitem_win", 32'(win), 32'd0);
        cyc(DN);
        chk("noitem_pos", {28'd0, pos_y, pos_x}, 32'hA);
        chk("noitem_bump", 32'(bump), 32'd0);
        chk("noitem_st_hold", 32'(game_state), 32'd4);
        pulse_start();
        chk_home("start2");

        // wizard lore takes priority over the sword
        cyc(DE);
        cyc(DE);
        chk("wiz_room", 32'(room_onehot), 32'h004);
        chk("wiz_wz", 32'(wz), 32'd1);
        cyc(DW);
        cyc(DW);
        cyc(DS);
        cyc(DS);
        chk("wiz_sw", {30'd0, sw, wz}, 32'h3);
        cyc(DE);
        cyc(DE);
        chk("wiz_combat", 32'(game_state), 32'd1);
        cyc(NONE);
        chk("wiz_depart", 32'(game_state), 32'd3);
        chk("wiz_win", 32'(win), 32'd1);
        chk("wiz_moves", 32'(moves), 32'd8);
        pulse_start();
        chk_home("start3");

        // timeout: 20 alternating moves
        for (int i = 0; i < 19; i++) begin
            cyc((i % 2 == 0) ? DE : DW);
        end
        chk("to_m19", 32'(moves), 32'd19);
        chk("to_st19", 32'(game_state), 32'd0);
        cyc(DW);
        chk("to_m20", 32'(moves), 32'd20);
        chk("to_dead", 32'(dead), 32'd1);
        chk("to_state", 32'(game_state), 32'd4);
        chk("to_room", 32'(room_onehot), 32'h001);
        cyc(DE);
        chk("to_hold", 32'(room_onehot), 32'h001);
        pulse_start();

        // reset while in combat
        cyc(DS);
        cyc(DS);
        cyc(DE);
        cyc(DE);
        chk("rst_combat", 32'(game_state), 32'd1);
        chk("rst_sw_set", 32'(sw), 32'd1);
        reset = 1'b1;
        start = 1'b1;
        cyc(DN);
        reset = 1'b0;
        start = 1'b0;
        chk_home("rst_mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
